// File: rtl/quiz_buzzer_arbiter.sv
// N-contestant quiz buzzer arbiter: first eligible press after arming wins, then a seconds countdown runs.
// Optional `define QUIZ_REARM_EN lets the host reject an answer, lock that player out and re-arm the round.
module quiz_buzzer_arbiter #(
    parameter int unsigned N_PLAYERS   = 3,
    parameter int unsigned ID_W        = 4,
    parameter int unsigned TICK_DIV    = 50000000,
    parameter int unsigned ANSWER_SECS = 30
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 clear,
    input  logic                 reject,
    input  logic [N_PLAYERS-1:0] buzz,
    output logic [ID_W-1:0]      winner_id,
    output logic                 winner_valid,
    output logic                 armed,
    output logic [7:0]           secs_left,
    output logic [N_PLAYERS-1:0] false_start,
    output logic                 beep
);

    localparam int unsigned TICK_W = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [7:0]        SECS_INIT = 8'(ANSWER_SECS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_ANSWER,
        S_EXPIRED
    } state_t;

    state_t                state, state_n;
    logic [N_PLAYERS-1:0]  buzz_q;
    logic [N_PLAYERS-1:0]  rise;
    logic [N_PLAYERS-1:0]  eligible;
    logic [TICK_W-1:0]     tick, tick_n;
    logic [ID_W-1:0]       id_n;
    logic                  valid_n;
    logic [7:0]            secs_n;
    logic [N_PLAYERS-1:0]  fs_n;
    logic                  beep_n;
    logic                  win_found;
    logic [ID_W-1:0]       win_idx;

    assign rise     = buzz & ~buzz_q;
    assign eligible = rise & ~false_start;

`ifndef QUIZ_REARM_EN
    logic unused_reject;
    assign unused_reject = reject;
`endif

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < N_PLAYERS; i++) begin
            if (eligible[i] && !win_found) begin
                win_found = 1'b1;
                win_idx   = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_n = state;
        tick_n  = tick;
        id_n    = winner_id;
        valid_n = winner_valid;
        secs_n  = secs_left;
        fs_n    = false_start;
        beep_n  = beep;

        case (state)
            S_IDLE: begin
                fs_n = false_start | rise;
                if (start) begin
                    state_n = S_ARMED;
                    secs_n  = SECS_INIT;
                end
            end
            S_ARMED: begin
                if (win_found) begin
                    state_n = S_ANSWER;
                    id_n    = win_idx;
                    valid_n = 1'b1;
                    tick_n  = '0;
                end
            end
            S_ANSWER: begin
                // Tick cleared on the win, so the first second is a full TICK_DIV cycles.
                if (tick == TICK_LAST) begin
                    tick_n = '0;
                    secs_n = secs_left - 8'd1;
                    if (secs_left == 8'd1) begin
                        state_n = S_EXPIRED;
                        beep_n  = 1'b1;
                    end
                end else begin
                    tick_n = tick + TICK_ONE;
                end
            end
            S_EXPIRED: begin
                beep_n = 1'b1;
                secs_n = '0;
            end
            default: state_n = S_IDLE;
        endcase

`ifdef QUIZ_REARM_EN
        if (reject && (state == S_ANSWER || state == S_EXPIRED)) begin
            for (int unsigned i = 0; i < N_PLAYERS; i++) begin
                if (winner_id == ID_W'(i)) begin
                    fs_n[i] = 1'b1;
                end
            end
            state_n = S_ARMED;
            id_n    = '0;
            valid_n = 1'b0;
            secs_n  = SECS_INIT;
            beep_n  = 1'b0;
            tick_n  = '0;
        end
`endif

        if (clear) begin
            state_n = S_IDLE;
            id_n    = '0;
            valid_n = 1'b0;
            secs_n  = '0;
            fs_n    = '0;
            beep_n  = 1'b0;
            tick_n  = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            buzz_q       <= '0;
            tick         <= '0;
            winner_id    <= '0;
            winner_valid <= 1'b0;
            armed        <= 1'b0;
            secs_left    <= '0;
            false_start  <= '0;
            beep         <= 1'b0;
        end else begin
            state        <= state_n;
            buzz_q       <= buzz;
            tick         <= tick_n;
            winner_id    <= id_n;
            winner_valid <= valid_n;
            armed        <= (state_n == S_ARMED);
            secs_left    <= secs_n;
            false_start  <= fs_n;
            beep         <= beep_n;
        end
    end

endmodule

// File: tb/tb_quiz_buzzer_arbiter.sv
// Scoreboard bench for quiz_buzzer_arbiter: driver pushes model predictions, monitor compares after each clock.
module tb_quiz_buzzer_arbiter;

    localparam int unsigned NP    = 4;
    localparam int unsigned IDW   = 4;
    localparam int unsigned TD    = 4;
    localparam int unsigned AS    = 3;
    localparam int unsigned TOTAL = AS * TD;

    localparam int P_IDLE   = 0;
    localparam int P_ARMED  = 1;
    localparam int P_LOCKED = 2;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic           clear = 1'b0;
    logic           reject = 1'b0;
    logic [NP-1:0]  buzz = '0;
    logic [IDW-1:0] winner_id;
    logic           winner_valid;
    logic           armed;
    logic [7:0]     secs_left;
    logic [NP-1:0]  false_start;
    logic           beep;

    always #5 clock = ~clock;

    quiz_buzzer_arbiter #(
        .N_PLAYERS   (NP),
        .ID_W        (IDW),
        .TICK_DIV    (TD),
        .ANSWER_SECS (AS)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .clear        (clear),
        .reject       (reject),
        .buzz         (buzz),
        .winner_id    (winner_id),
        .winner_valid (winner_valid),
        .armed        (armed),
        .secs_left    (secs_left),
        .false_start  (false_start),
        .beep         (beep)
    );

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           valid;
        logic           armed;
        logic [7:0]     secs;
        logic [NP-1:0]  fs;
        logic           beep;
    } out_t;

    out_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;

    // Reference model: round phase, who won, and cycles elapsed since the win.
    int          m_phase   = P_IDLE;
    int          m_winner  = 0;
    int          m_elapsed = 0;
    bit [NP-1:0] m_fs      = '0;
    bit [NP-1:0] m_prev    = '0;

    task model_step(input bit r, input bit s, input bit c, input bit j, input bit [NP-1:0] b);
        bit [NP-1:0] rises;
        bit          found;
        rises = b & ~m_prev;
        found = 1'b0;
        if (r || c) begin
            m_phase   = P_IDLE;
            m_fs      = '0;
            m_winner  = 0;
            m_elapsed = 0;
        end else if (m_phase == P_IDLE) begin
            m_fs = m_fs | rises;
            if (s) m_phase = P_ARMED;
        end else if (m_phase == P_ARMED) begin
            for (int i = 0; i < int'(NP); i++) begin
                if (!found && rises[i] && !m_fs[i]) begin
                    found     = 1'b1;
                    m_winner  = i;
                    m_phase   = P_LOCKED;
                    m_elapsed = 0;
                end
            end
        end else begin
`ifdef QUIZ_REARM_EN
            if (j) begin
                m_fs[m_winner] = 1'b1;
                m_phase        = P_ARMED;
            end else
`endif
            if (m_elapsed < int'(TOTAL)) m_elapsed++;
        end
        m_prev = r ? '0 : b;
    endtask

    function automatic out_t model_out();
        out_t e;
        bit   expired;
        expired = (m_phase == P_LOCKED) && (m_elapsed >= int'(TOTAL));
        e.valid = (m_phase == P_LOCKED);
        e.armed = (m_phase == P_ARMED);
        e.id    = e.valid ? IDW'(m_winner) : '0;
        if (m_phase == P_IDLE)      e.secs = 8'd0;
        else if (m_phase == P_ARMED) e.secs = 8'(AS);
        else if (expired)           e.secs = 8'd0;
        else                        e.secs = 8'(int'(AS) - m_elapsed / int'(TD));
        e.fs   = m_fs;
        e.beep = expired;
        return e;
    endfunction

    task automatic step(input bit r, input bit s, input bit c, input bit j, input bit [NP-1:0] b);
        @(negedge clock);
        reset  = r;
        start  = s;
        clear  = c;
        reject = j;
        buzz   = b;
        model_step(r, s, c, j, b);
        exp_q.push_back(model_out());
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        out_t e;
        out_t a;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {winner_id, winner_valid, armed, secs_left, false_start, beep};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs cyc=%0d got id=%0d valid=%b armed=%b secs=%0d fs=%b beep=%b expected id=%0d valid=%b armed=%b secs=%0d fs=%b beep=%b",
                             cyc, a.id, a.valid, a.armed, a.secs, a.fs, a.beep,
                             e.id, e.valid, e.armed, e.secs, e.fs, e.beep);
                end
            end
        end
    end

    initial begin
        bit [NP-1:0] b;
        bit [NP-1:0] last_b;
        last_b = '0;

        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        idle(2);

        // Basic win and full countdown to expiry
        step(0, 1, 0, 0, 4'b0000);
        step(0, 0, 0, 0, 4'b0100);
        idle(15);
        step(0, 0, 1, 0, 4'b0000);

        // Simultaneous presses, later press ignored
        step(0, 1, 0, 0, 4'b0000);
        step(0, 0, 0, 0, 4'b1010);
        step(0, 0, 0, 0, 4'b0000);
        step(0, 0, 0, 0, 4'b0001);
        idle(2);
        step(0, 0, 1, 0, 4'b0000);

        // False start in IDLE locks player 0 out
        step(0, 0, 0, 0, 4'b0001);
        step(0, 0, 0, 0, 4'b0000);
        step(0, 1, 0, 0, 4'b0000);
        step(0, 0, 0, 0, 4'b0001);
        step(0, 0, 0, 0, 4'b0000);
        step(0, 0, 0, 0, 4'b1000);
        idle(2);
        step(0, 0, 1, 0, 4'b0000);

        // Button held from IDLE through start
        step(0, 0, 0, 0, 4'b0100);
        step(0, 0, 0, 0, 4'b0100);
        step(0, 1, 0, 0, 4'b0100);
        repeat (3) step(0, 0, 0, 0, 4'b0100);
        step(0, 0, 0, 0, 4'b0000);
        step(0, 0, 0, 0, 4'b0100);
        step(0, 0, 1, 0, 4'b0000);

        // Every player flagged: ARMED holds until clear
        step(0, 0, 0, 0, 4'b1111);
        step(0, 1, 0, 0, 4'b0000);
        step(0, 0, 0, 0, 4'b1111);
        idle(2);
        step(0, 0, 1, 0, 4'b0000);

        // clear+start together mid-count, then reset mid-count
        step(0, 1, 0, 0, 4'b0000);
        step(0, 0, 0, 0, 4'b0010);
        idle(5);
        step(0, 1, 1, 0, 4'b0000);
        idle(2);
        step(0, 1, 0, 0, 4'b0000);
        step(0, 0, 0, 0, 4'b0010);
        idle(5);
        step(1, 0, 0, 0, 4'b0010);
        step(0, 0, 0, 0, 4'b0010);
        idle(2);

        // Reject after a win, and reject after expiry
        step(0, 1, 0, 0, 4'b0000);
        step(0, 0, 0, 0, 4'b0010);
        idle(2);
        step(0, 0, 0, 1, 4'b0000);
        step(0, 0, 0, 0, 4'b0010);
        step(0, 0, 0, 0, 4'b0000);
        step(0, 0, 0, 0, 4'b0001);
        idle(14);
        step(0, 0, 0, 1, 4'b0000);
        idle(2);
        step(0, 0, 1, 1, 4'b0000);
        idle(1);

        // Randomised traffic
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(1) == 0) begin
                b = last_b;
            end else begin
                for (int i = 0; i < int'(NP); i++) b[i] = ($urandom_range(4) == 0);
            end
            last_b = b;
            step(($urandom_range(299) == 0), ($urandom_range(3) == 0),
                 ($urandom_range(59) == 0), ($urandom_range(19) == 0), b);
        end

        repeat (2) @(posedge clock);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
